// File: rtl/prediction_score_trainer_pkg.sv
// Shared trend encoding and decode width for the predictor score trainer.
// Imported by the top level and by the per-predictor score unit.
package prediction_score_trainer_pkg;

  typedef enum logic [1:0] {
    TREND_STRONG_DISTRUST = 2'd0,
    TREND_WEAK_DISTRUST   = 2'd1,
    TREND_WEAK_TRUST      = 2'd2,
    TREND_STRONG_TRUST    = 2'd3
  } trend_e;

  localparam trend_e TREND_RESET    = TREND_WEAK_TRUST;
  localparam int     TREND_DECODE_W = 4;

endpackage

// File: rtl/prediction_score_trainer_score_unit.sv
// Per-predictor scoring: saturating confidence counter with halving decay
// and a four-state trend FSM with a registered one-hot decode.
module predictor_score_unit
  import prediction_score_trainer_pkg::*;
#(
  parameter int STAT_COUNTER_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          update_en,
  input  logic                          correct,
  output logic [STAT_COUNTER_WIDTH-1:0] stat_count,
  output logic [TREND_DECODE_W-1:0]     trend_decode
);

  localparam logic [STAT_COUNTER_WIDTH-1:0] STAT_MAX = '1;

  logic [STAT_COUNTER_WIDTH-1:0] stat_q, stat_d;
  trend_e                        trend_q, trend_d;
  logic [TREND_DECODE_W-1:0]     decode_q, decode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q   <= '0;
      trend_q  <= TREND_RESET;
      decode_q <= TREND_DECODE_W'(1) << TREND_RESET;
    end else begin
      stat_q   <= stat_d;
      trend_q  <= trend_d;
      decode_q <= decode_d;
    end
  end

  always_comb begin
    stat_d  = stat_q;
    trend_d = trend_q;
    if (update_en) begin
      if (correct) begin
        stat_d = (stat_q == STAT_MAX) ? stat_q : stat_q + 1'b1;
        unique case (trend_q)
          TREND_STRONG_DISTRUST: trend_d = TREND_WEAK_DISTRUST;
          TREND_WEAK_DISTRUST:   trend_d = TREND_WEAK_TRUST;
          default:               trend_d = TREND_STRONG_TRUST;
        endcase
      end else begin
        stat_d = stat_q >> 1;
        unique case (trend_q)
          TREND_STRONG_TRUST: trend_d = TREND_WEAK_TRUST;
          TREND_WEAK_TRUST:   trend_d = TREND_WEAK_DISTRUST;
          default:            trend_d = TREND_STRONG_DISTRUST;
        endcase
      end
    end
    decode_d = TREND_DECODE_W'(1) << trend_d;
  end

  assign stat_count   = stat_q;
  assign trend_decode = decode_q;

endmodule

// File: rtl/prediction_score_trainer.sv
// Tournament trainer: queues SP/LHP/GHP predictions at fetch, scores them in
// order at resolve, and drives the stat counts and trend decodes for the arbiter.
module prediction_score_trainer
  import prediction_score_trainer_pkg::*;
#(
  parameter int STAT_COUNTER_WIDTH = 5,
  parameter int QUEUE_DEPTH        = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 record_valid,
  output logic                                 record_ready,
  input  logic                                 SP_prediction_result,
  input  logic                                 LHP_prediction_result,
  input  logic                                 GHP_prediction_result,
  input  logic                                 resolve_valid,
  input  logic                                 resolve_taken,
  input  logic                                 flush,
  output logic [TREND_DECODE_W-1:0]            SP_trend_decode,
  output logic [TREND_DECODE_W-1:0]            LHP_trend_decode,
  output logic [TREND_DECODE_W-1:0]            GHP_trend_decode,
  output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count,
  output logic [$clog2(QUEUE_DEPTH):0]         occupancy,
  output logic                                 underflow_err
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int PW = AW + 1;

  // Entry layout: bit 2 = SP, bit 1 = LHP, bit 0 = GHP.
  logic [2:0]    mem_q [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          underflow_q;
  logic          push, pop;
  logic [2:0]    head, correct;

  logic [STAT_COUNTER_WIDTH-1:0] stat_w   [3];
  logic [TREND_DECODE_W-1:0]     decode_w [3];

  assign occupancy    = wr_ptr_q - rd_ptr_q;
  assign record_ready = (occupancy != PW'(QUEUE_DEPTH));
  assign push         = record_valid && record_ready && !flush;
  assign pop          = resolve_valid && (occupancy != '0);
  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign correct      = ~(head ^ {3{resolve_taken}});

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    // The pop above still feeds the scorers; only the queue is cleared.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      underflow_q <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      underflow_q <= resolve_valid && (occupancy == '0);
      if (push)
        mem_q[wr_ptr_q[AW-1:0]] <= {SP_prediction_result, LHP_prediction_result,
                                    GHP_prediction_result};
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_score
      predictor_score_unit #(
        .STAT_COUNTER_WIDTH(STAT_COUNTER_WIDTH)
      ) u_score (
        .clk          (clk),
        .rst_n        (rst_n),
        .update_en    (pop),
        .correct      (correct[gi]),
        .stat_count   (stat_w[gi]),
        .trend_decode (decode_w[gi])
      );
    end
  endgenerate

  assign SP_stat_count    = stat_w[2];
  assign LHP_stat_count   = stat_w[1];
  assign GHP_stat_count   = stat_w[0];
  assign SP_trend_decode  = decode_w[2];
  assign LHP_trend_decode = decode_w[1];
  assign GHP_trend_decode = decode_w[0];
  assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_prediction_score_trainer.sv
// Bench for prediction_score_trainer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_prediction_score_trainer;

  localparam int W     = 5;
  localparam int DEPTH = 4;
  localparam int SMAX  = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic record_valid = 1'b0, record_ready;
  logic sp_in = 1'b0, lhp_in = 1'b0, ghp_in = 1'b0;
  logic resolve_valid = 1'b0, resolve_taken = 1'b0, flush = 1'b0;
  logic [3:0] sp_dec, lhp_dec, ghp_dec;
  logic [W-1:0] sp_stat, lhp_stat, ghp_stat;
  logic [$clog2(DEPTH):0] occ;
  logic und;

  prediction_score_trainer #(.STAT_COUNTER_WIDTH(W), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .record_valid(record_valid), .record_ready(record_ready),
    .SP_prediction_result(sp_in), .LHP_prediction_result(lhp_in),
    .GHP_prediction_result(ghp_in),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .SP_trend_decode(sp_dec), .LHP_trend_decode(lhp_dec), .GHP_trend_decode(ghp_dec),
    .SP_stat_count(sp_stat), .LHP_stat_count(lhp_stat), .GHP_stat_count(ghp_stat),
    .occupancy(occ), .underflow_err(und)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit verbose  = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {SP,LHP,GHP} bits plus plain integer scores.
  bit [2:0] mq[$];
  int m_stat[3];
  int m_trend[3];
  bit m_und;
  int m_sz;
  bit m_rdy;
  bit [2:0] m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      for (int p = 0; p < 3; p++) begin
        m_stat[p]  = 0;
        m_trend[p] = 2;
      end
      m_und = 1'b0;
    end else begin
      m_sz  = mq.size();
      m_rdy = (m_sz != DEPTH);
      m_und = resolve_valid && (m_sz == 0);
      if (resolve_valid && m_sz > 0) begin
        m_e = mq.pop_front();
        for (int p = 0; p < 3; p++) begin
          if (m_e[p] == resolve_taken) begin
            m_stat[p]  = (m_stat[p] < SMAX) ? m_stat[p] + 1 : SMAX;
            m_trend[p] = (m_trend[p] < 3) ? m_trend[p] + 1 : 3;
          end else begin
            m_stat[p]  = m_stat[p] / 2;
            m_trend[p] = (m_trend[p] > 0) ? m_trend[p] - 1 : 0;
          end
        end
      end
      if (flush) mq.delete();
      else if (record_valid && m_rdy) mq.push_back({sp_in, lhp_in, ghp_in});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("sp_stat",  int'(sp_stat),  m_stat[2]);
      chk("lhp_stat", int'(lhp_stat), m_stat[1]);
      chk("ghp_stat", int'(ghp_stat), m_stat[0]);
      chk("sp_dec",   int'(sp_dec),   1 << m_trend[2]);
      chk("lhp_dec",  int'(lhp_dec),  1 << m_trend[1]);
      chk("ghp_dec",  int'(ghp_dec),  1 << m_trend[0]);
      chk("occupancy", int'(occ), mq.size());
      chk("record_ready", int'(record_ready), int'(mq.size() != DEPTH));
      chk("underflow_err", int'(und), int'(m_und));
    end
  end

  // One cycle of stimulus: drive, take the edge, return inputs to idle.
  task automatic step(input bit rv, input bit [2:0] bits, input bit rs,
                      input bit tk, input bit fl);
    record_valid  = rv;
    {sp_in, lhp_in, ghp_in} = bits;
    resolve_valid = rs;
    resolve_taken = tk;
    flush         = fl;
    @(posedge clk);
    #1;
    if (verbose)
      $display("txn t=%0t rec=%0b bits=%03b res=%0b taken=%0b flush=%0b -> occ=%0d",
               $time, rv, bits, rs, tk, fl, occ);
    record_valid  = 1'b0;
    resolve_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sp_stat"}, int'(sp_stat), 0);
    chk({tag, "_lhp_stat"}, int'(lhp_stat), 0);
    chk({tag, "_ghp_stat"}, int'(ghp_stat), 0);
    chk({tag, "_sp_dec"}, int'(sp_dec), 4);
    chk({tag, "_lhp_dec"}, int'(lhp_dec), 4);
    chk({tag, "_ghp_dec"}, int'(ghp_dec), 4);
    chk({tag, "_ready"}, int'(record_ready), 1);
    chk({tag, "_occ"}, int'(occ), 0);
    chk({tag, "_und"}, int'(und), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");

    // Mixed correctness on a single record.
    step(1, 3'b101, 0, 0, 0);
    step(0, 3'b000, 1, 1, 0);
    @(negedge clk);
    chk("t2_sp_stat", int'(sp_stat), 1);
    chk("t2_ghp_stat", int'(ghp_stat), 1);
    chk("t2_lhp_stat", int'(lhp_stat), 0);
    chk("t2_sp_dec", int'(sp_dec), 8);
    chk("t2_ghp_dec", int'(ghp_dec), 8);
    chk("t2_lhp_dec", int'(lhp_dec), 2);
    chk("t2_occ", int'(occ), 0);

    // Saturation, then halving decay.
    step(1, 3'b111, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 3'b111, 1, 1, 0);
    step(0, 3'b000, 1, 1, 0);
    @(negedge clk);
    chk("sat_sp_stat", int'(sp_stat), 31);
    chk("sat_lhp_stat", int'(lhp_stat), 31);
    chk("sat_ghp_dec", int'(ghp_dec), 8);
    step(1, 3'b111, 0, 0, 0);
    step(0, 3'b000, 1, 0, 0);
    @(negedge clk);
    chk("decay_sp_stat", int'(sp_stat), 15);
    chk("decay_ghp_stat", int'(ghp_stat), 15);
    chk("decay_lhp_dec", int'(lhp_dec), 4);

    // Fill, overflow attempt, then record+resolve when full.
    step(1, 3'b100, 0, 0, 0);
    step(1, 3'b010, 0, 0, 0);
    step(1, 3'b001, 0, 0, 0);
    step(1, 3'b110, 0, 0, 0);
    step(1, 3'b011, 0, 0, 0);
    @(negedge clk);
    chk("full_ready", int'(record_ready), 0);
    chk("full_occ", int'(occ), 4);
    step(1, 3'b111, 1, 1, 0);
    @(negedge clk);
    chk("full_pop_occ", int'(occ), 3);
    chk("full_pop_sp_stat", int'(sp_stat), 16);
    chk("full_pop_lhp_stat", int'(lhp_stat), 7);

    // Flush with resolve, then underflow.
    step(0, 3'b000, 1, 1, 1);
    @(negedge clk);
    chk("flush_occ", int'(occ), 0);
    chk("flush_lhp_stat", int'(lhp_stat), 8);
    step(0, 3'b000, 1, 1, 0);
    @(negedge clk);
    chk("underflow_pulse", int'(und), 1);
    chk("underflow_lhp_stat", int'(lhp_stat), 8);
    step(0, 3'b000, 0, 0, 0);
    @(negedge clk);
    chk("underflow_clear", int'(und), 0);

    // Asynchronous reset mid-queue.
    step(1, 3'b111, 0, 0, 0);
    step(1, 3'b000, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_occ", int'(occ), 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 6, 3'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prediction_score_trainer.md
Name: prediction_score_trainer

Overview:
- Training side of the three-way branch predictor tournament (SP static, LHP local-history, GHP global-history).
- Queues each predictor's individual prediction at fetch time, then retires the queue in order as branches resolve.
- At retirement it scores each predictor and maintains the per-predictor stat counters and trend decodes that the prediction arbiter consumes.
- Sits between the fetch-stage predictors and the execute-stage branch resolution.

Parameters:
- STAT_COUNTER_WIDTH, 5, width of each per-predictor confidence counter.
- QUEUE_DEPTH, 4, number of in-flight branch records; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- record_valid  in  1  a predicted branch enters the pipeline this cycle
- record_ready  out  1  queue not full; a record is accepted only when record_valid and record_ready are both high
- SP_prediction_result  in  1  SP taken/not-taken for the recorded branch
- LHP_prediction_result  in  1  LHP taken/not-taken for the recorded branch
- GHP_prediction_result  in  1  GHP taken/not-taken for the recorded branch
- resolve_valid  in  1  the oldest in-flight branch resolves this cycle
- resolve_taken  in  1  actual branch outcome
- flush  in  1  discard all in-flight records (wrong-path squash)
- SP_trend_decode  out  4  one-hot SP trend state
- LHP_trend_decode  out  4  one-hot LHP trend state
- GHP_trend_decode  out  4  one-hot GHP trend state
- SP_stat_count  out  STAT_COUNTER_WIDTH  SP confidence
- LHP_stat_count  out  STAT_COUNTER_WIDTH  LHP confidence
- GHP_stat_count  out  STAT_COUNTER_WIDTH  GHP confidence
- occupancy  out  clog2(QUEUE_DEPTH)+1  number of records in the queue
- underflow_err  out  1  one-cycle pulse: resolve arrived with the queue empty

Behaviour:
- Reset (asynchronous, rst_n low):
  - queue empty, occupancy 0, record_ready 1, underflow_err 0
  - all stat counts 0
  - all trend states 2, so each trend_decode = 4'b0100
- Queue: circular FIFO. Each entry holds {SP,LHP,GHP} prediction bits. Read and write pointers are clog2(QUEUE_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty on wrap-around.
- record_ready = (occupancy != QUEUE_DEPTH), combinational from registered state.
- A record offered while the queue is full is dropped. This is not an error.
- Resolve with occupancy > 0:
  - pop the head entry.
  - for each predictor P: correct = (P_bit == resolve_taken).
  - correct: stat = min(stat+1, 2^W-1); trend = min(trend+1, 3).
  - wrong: stat = stat >> 1; trend = max(trend-1, 0).
  - all three predictors are updated in the same cycle.
  - the updated stat and trend values are visible on the outputs on the next clock edge (latency 1).
- Resolve with occupancy == 0:
  - no counter changes.
  - underflow_err = 1 for exactly the following cycle.
  - a same-cycle record does not bypass to the resolve.
- Simultaneous record and resolve with 0 < occupancy < DEPTH: push and pop both happen; occupancy is unchanged.
- Simultaneous record and resolve with the queue full: the pop happens; the push is dropped because record_ready was 0 in that cycle.
- Flush:
  - next edge: pointers equal, occupancy 0.
  - stat and trend state are retained.
  - a same-cycle resolve is applied to the counters first, then the queue is cleared.
  - a same-cycle record is discarded.
- trend_decode[i] = (trend == i), always exactly one-hot.
- Arbiter semantics: trend 0 forces the arbiter to ignore that predictor's stat; trend 2 or 3 means the predictor wins ties.
- All outputs are registered except record_ready and occupancy; those two are combinational from registered pointers.
- rst_n asserted mid-operation: every register returns to its reset value immediately. No partial update completes.

Decomposition:
- define.v holds:
  - the trend encoding constants: TREND_STRONG_DISTRUST=0, WEAK_DISTRUST=1, WEAK_TRUST=2, STRONG_TRUST=3
  - TREND_RESET = WEAK_TRUST
  - the 4-bit decode width
- Sub-module predictor_score_unit, instantiated three times. Inputs: clk, rst_n, update_en, correct. Outputs: stat_count, trend_decode. It owns the saturating counter, halving decay and the trend FSM.
- The top level owns the FIFO, the flush logic and the correctness compare.

Test Plan:
- Reset release, no activity -> all stat 0, all trend_decode 4'b0100, record_ready 1, occupancy 0.
- Record {SP=1,LHP=0,GHP=1}, resolve_taken=1 -> next cycle: SP/GHP stat 1 and decode 4'b1000; LHP stat 0 and decode 4'b0010; occupancy 0.
- 40 consecutive all-correct resolves (W=5) -> stats saturate at 31 and trends at 4'b1000. Then one all-wrong resolve -> stats 15, decode 4'b0100.
- Fill 4 records, attempt a 5th -> record_ready 0 and occupancy stays 4. Then record and resolve in the same cycle -> occupancy 3, and only the head entry is scored.
- Occupancy 3, flush asserted together with a resolve -> the head is scored, then occupancy 0. The next resolve pulses underflow_err, with stats unchanged.
- Assert rst_n low mid-queue (occupancy 2, stats nonzero) -> everything returns to reset values asynchronously, before the next clock edge.
